// File: rtl/mips_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package mips_pkg;

  localparam int ANCHO_PALABRA = 32;
  localparam int LATENCIA_MAX  = 15;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    ESPERA    = 2'd1,
    RESPUESTA = 2'd2
  } estado_t;

endpackage

// File: rtl/responder_memoria_datos_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
interface responder_memoria_datos_if;
  import mips_pkg::*;

  logic                     mem_leer;
  logic                     mem_escribir;
  logic [ANCHO_PALABRA-1:0] direccion;
  logic [ANCHO_PALABRA-1:0] dato_escribir;
  logic [ANCHO_PALABRA-1:0] dato_leer;
  logic                     listo;
  logic                     ocupado;
  logic                     error_alineacion;

  modport master (
    output mem_leer, mem_escribir, direccion, dato_escribir,
    input  dato_leer, listo, ocupado, error_alineacion
  );

  modport slave (
    input  mem_leer, mem_escribir, direccion, dato_escribir,
    output dato_leer, listo, ocupado, error_alineacion
  );

endinterface

// File: rtl/contador_espera.sv
// Loadable down-counter that times the wait states of an accepted access.
module contador_espera #(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cargar,
  input  logic [ANCHO-1:0] i_valor,
  input  logic             i_decrementar,
  output logic             o_cero
);

  logic [ANCHO-1:0] r_cuenta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cuenta <= '0;
    end else if (i_cargar) begin
      r_cuenta <= i_valor;
    end else if (i_decrementar && (r_cuenta != '0)) begin
      r_cuenta <= r_cuenta - 1'b1;
    end
  end

  assign o_cero = (r_cuenta == '0);

endmodule

// File: rtl/responder_memoria_datos.sv
// Data-memory responder for the MEM stage: multi-cycle RAM with listo/ocupado handshake.
// Optional MEM_CHECK_ALIGN_EN: misaligned accesses still handshake but are suppressed and flagged.
module responder_memoria_datos
  import mips_pkg::*;
#(
  parameter int PROFUNDIDAD = 256,
  parameter int LATENCIA    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  responder_memoria_datos_if.slave  bus
);

  // state     | meaning
  // REPOSO    | idle, accepts a request
  // ESPERA    | counting wait states
  // RESPUESTA | listo cycle; RAM access happened on entry
  localparam int AW         = $clog2(PROFUNDIDAD);
  localparam int ANCHO_CONT = $clog2(LATENCIA_MAX + 1);
  localparam int CARGA_INT  = (LATENCIA > 0) ? LATENCIA - 1 : 0;
  localparam logic [ANCHO_CONT-1:0] CARGA_ESPERA = CARGA_INT[ANCHO_CONT-1:0];

  estado_t r_estado;
  estado_t w_estado_sig;

  logic [ANCHO_PALABRA-1:0] r_ram [PROFUNDIDAD];
  logic [ANCHO_PALABRA-1:0] r_dato_leer;
  logic [ANCHO_PALABRA-1:0] r_dato;
  logic [AW-1:0]            r_indice;
  logic                     r_es_escritura;
  logic                     r_es_lectura;
  logic                     r_desalineado;

  logic                     w_peticion;
  logic                     w_aceptar;
  logic                     w_cargar;
  logic                     w_decrementar;
  logic                     w_cero;
  logic                     w_fin;
  logic                     w_desal_entrada;
  logic                     w_es_escritura;
  logic                     w_es_lectura;
  logic                     w_desalineado;
  logic [AW-1:0]            w_indice;
  logic [ANCHO_PALABRA-1:0] w_dato;
  logic                     w_unused_bits;

  assign w_peticion = bus.mem_leer | bus.mem_escribir;

`ifdef MEM_CHECK_ALIGN_EN
  assign w_desal_entrada = |bus.direccion[1:0];
`else
  assign w_desal_entrada = 1'b0;
`endif

  assign w_unused_bits = ^{bus.direccion[ANCHO_PALABRA-1:AW+2], bus.direccion[1:0]};

  // With zero wait states the RAM access lands on the accept edge, so live inputs are used.
  always_comb begin
    w_es_escritura = r_es_escritura;
    w_es_lectura   = r_es_lectura;
    w_indice       = r_indice;
    w_dato         = r_dato;
    w_desalineado  = r_desalineado;
    if (r_estado == REPOSO) begin
      w_es_escritura = bus.mem_escribir;
      w_es_lectura   = bus.mem_leer & ~bus.mem_escribir;
      w_indice       = bus.direccion[AW+1:2];
      w_dato         = bus.dato_escribir;
      w_desalineado  = w_desal_entrada;
    end
  end

  always_comb begin
    w_estado_sig  = r_estado;
    w_aceptar     = 1'b0;
    w_cargar      = 1'b0;
    w_decrementar = 1'b0;
    w_fin         = 1'b0;
    case (r_estado)
      REPOSO: begin
        if (w_peticion) begin
          w_aceptar = 1'b1;
          if (LATENCIA == 0) begin
            w_fin        = 1'b1;
            w_estado_sig = RESPUESTA;
          end else begin
            w_cargar     = 1'b1;
            w_estado_sig = ESPERA;
          end
        end
      end
      ESPERA: begin
        if (w_cero) begin
          w_fin        = 1'b1;
          w_estado_sig = RESPUESTA;
        end else begin
          w_decrementar = 1'b1;
        end
      end
      RESPUESTA: w_estado_sig = REPOSO;
      default:   w_estado_sig = REPOSO;
    endcase
  end

  contador_espera #(
    .ANCHO (ANCHO_CONT)
  ) u_contador_espera (
    .clk           (clk),
    .reset         (reset),
    .i_cargar      (w_cargar),
    .i_valor       (CARGA_ESPERA),
    .i_decrementar (w_decrementar),
    .o_cero        (w_cero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_es_escritura <= 1'b0;
      r_es_lectura   <= 1'b0;
      r_indice       <= '0;
      r_dato         <= '0;
      r_desalineado  <= 1'b0;
    end else if (w_aceptar) begin
      r_es_escritura <= bus.mem_escribir;
      r_es_lectura   <= bus.mem_leer & ~bus.mem_escribir;
      r_indice       <= bus.direccion[AW+1:2];
      r_dato         <= bus.dato_escribir;
      r_desalineado  <= w_desal_entrada;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado    <= REPOSO;
      r_dato_leer <= '0;
    end else begin
      r_estado <= w_estado_sig;
      if (w_fin && w_es_lectura) begin
        r_dato_leer <= w_desalineado ? '0 : r_ram[w_indice];
      end
    end
  end

  // RAM is intentionally not reset; an aborted access never reaches this enable.
  always_ff @(posedge clk) begin
    if (w_fin && w_es_escritura && !w_desalineado) begin
      r_ram[w_indice] <= w_dato;
    end
  end

  assign bus.listo     = (r_estado == RESPUESTA);
  assign bus.ocupado   = ((r_estado == REPOSO) && w_peticion) || (r_estado == ESPERA);
  assign bus.dato_leer = r_dato_leer;

`ifdef MEM_CHECK_ALIGN_EN
  assign bus.error_alineacion = (r_estado == RESPUESTA) && r_desalineado;
`else
  assign bus.error_alineacion = 1'b0;
`endif

endmodule

// File: tb/tb_responder_memoria_datos.sv
// Randomized bench for responder_memoria_datos: two instances (2 and 0 wait states) vs a word-array model.
module tb_responder_memoria_datos;

  localparam int PROF = 256;
  localparam int LAT0 = 2;
  localparam int LAT1 = 0;

`ifdef MEM_CHECK_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk;
  logic reset;

  responder_memoria_datos_if bus0 ();
  responder_memoria_datos_if bus1 ();

  responder_memoria_datos #(.PROFUNDIDAD(PROF), .LATENCIA(LAT0)) u_dut_lat2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  responder_memoria_datos #(.PROFUNDIDAD(PROF), .LATENCIA(LAT1)) u_dut_lat0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem_ref [2][PROF];
  logic [31:0] last_rd [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive(input int sel, input logic leer, input logic escr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel == 0) begin
      bus0.mem_leer = leer; bus0.mem_escribir = escr;
      bus0.direccion = addr; bus0.dato_escribir = data;
    end else begin
      bus1.mem_leer = leer; bus1.mem_escribir = escr;
      bus1.direccion = addr; bus1.dato_escribir = data;
    end
  endtask

  function automatic logic obs_listo(input int sel);
    return (sel == 0) ? bus0.listo : bus1.listo;
  endfunction

  function automatic logic obs_ocupado(input int sel);
    return (sel == 0) ? bus0.ocupado : bus1.ocupado;
  endfunction

  function automatic logic obs_err(input int sel);
    return (sel == 0) ? bus0.error_alineacion : bus1.error_alineacion;
  endfunction

  function automatic logic [31:0] obs_dato(input int sel);
    return (sel == 0) ? bus0.dato_leer : bus1.dato_leer;
  endfunction

  // One full request: present at a negedge, hold through listo, drop one cycle later.
  task automatic do_txn(input int sel, input logic leer, input logic escr,
                        input logic [31:0] addr, input logic [31:0] data);
    int  lat;
    int  ciclos;
    int  idx;
    bit  got;
    bit  desal;
    lat   = (sel == 0) ? LAT0 : LAT1;
    idx   = int'((addr >> 2) % PROF);
    desal = ALIGN_EN && (addr[1:0] != 2'b00);
    if (escr) begin
      if (!desal) mem_ref[sel][idx] = data;
    end else if (leer) begin
      last_rd[sel] = desal ? 32'h0 : mem_ref[sel][idx];
    end
    drive(sel, leer, escr, addr, data);
    #1;
    check_val("ocupado_acepta", 32'(obs_ocupado(sel)), 32'd1);
    ciclos = 0;
    got    = 1'b0;
    while (!got && ciclos < 20) begin
      @(negedge clk);
      ciclos++;
      if (obs_listo(sel)) got = 1'b1;
      else begin
        check_val("ocupado_espera", 32'(obs_ocupado(sel)), 32'd1);
        drive(sel, leer, escr, $urandom, $urandom);
      end
    end
    check_val("listo_timeout", 32'(got), 32'd1);
    check_val("latencia", 32'(ciclos), 32'(lat + 1));
    check_val("ocupado_listo", 32'(obs_ocupado(sel)), 32'd0);
    check_val("dato_leer", obs_dato(sel), last_rd[sel]);
    check_val("error_alineacion", 32'(obs_err(sel)), 32'(desal));
    @(negedge clk);
    check_val("listo_unico", 32'(obs_listo(sel)), 32'd0);
    drive(sel, 1'b0, 1'b0, $urandom, $urandom);
    @(negedge clk);
    check_val("listo_sin_dup", 32'(obs_listo(sel)), 32'd0);
    check_val("dato_leer_retenido", obs_dato(sel), last_rd[sel]);
  endtask

  initial begin
    int          sel;
    int          op;
    logic [31:0] addr;
    logic [31:0] a_ret;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check_val("rst_listo", 32'(obs_listo(s)), 32'd0);
      check_val("rst_ocupado", 32'(obs_ocupado(s)), 32'd0);
      check_val("rst_dato_leer", obs_dato(s), 32'h0);
      check_val("rst_error", 32'(obs_err(s)), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Fill both RAMs so every later read has a known expected value.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < PROF; i++)
        do_txn(s, 1'b0, 1'b1, 32'(i * 4), $urandom);

    // Reset in the middle of a store's wait states must discard it.
    drive(0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D);
    @(negedge clk);
    check_val("rst_mid_ocupado_espera", 32'(bus0.ocupado), 32'd1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    check_val("rst_mid_listo", 32'(bus0.listo), 32'd0);
    check_val("rst_mid_ocupado", 32'(bus0.ocupado), 32'd0);
    check_val("rst_mid_dato_leer", bus0.dato_leer, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("rst_mid_sin_listo", 32'(bus0.listo), 32'd0);
    end
    do_txn(0, 1'b1, 1'b0, 32'h10, 32'h0);

    // Store/load at 0x40 with two wait states, and a zero-wait-state load.
    do_txn(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    do_txn(0, 1'b1, 1'b0, 32'h40, 32'h0);
    check_val("lw_0x40", bus0.dato_leer, 32'hDEADBEEF);
    do_txn(1, 1'b1, 1'b0, 32'h40, 32'h0);

    // Address aliasing modulo the RAM depth.
    for (int s = 0; s < 2; s++) begin
      do_txn(s, 1'b0, 1'b1, 32'h4, 32'hA5A50000 + 32'(s));
      do_txn(s, 1'b1, 1'b0, 32'h4 + 32'(4 * PROF), 32'h0);
      check_val("alias", obs_dato(s), 32'hA5A50000 + 32'(s));
    end

    // Simultaneous read and write: the write wins, dato_leer is untouched.
    a_ret = bus0.dato_leer;
    do_txn(0, 1'b1, 1'b1, 32'h8, 32'h1234);
    check_val("both_dato_leer", bus0.dato_leer, a_ret);
    do_txn(0, 1'b1, 1'b0, 32'h8, 32'h0);
    check_val("both_escrito", bus0.dato_leer, 32'h1234);

    // Misaligned store at 0x42 then read the containing word.
    do_txn(0, 1'b0, 1'b1, 32'h42, 32'h0BADF00D);
    do_txn(0, 1'b1, 1'b0, 32'h40, 32'h0);
    do_txn(1, 1'b0, 1'b1, 32'h42, 32'h600DCAFE);
    do_txn(1, 1'b1, 1'b0, 32'h42, 32'h0);

    for (int n = 0; n < 300; n++) begin
      sel  = int'($urandom_range(0, 1));
      op   = int'($urandom_range(0, 3));
      addr = ($urandom << 10) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      case (op)
        1:       do_txn(sel, 1'b0, 1'b1, addr, $urandom);
        2:       do_txn(sel, 1'b1, 1'b1, addr, $urandom);
        default: do_txn(sel, 1'b1, 1'b0, addr, $urandom);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
